packet_rate_timer: RTL and testbench

Programmable packet-rate timer that tells the IR transmit path when to send a packet. It is the parametrised successor of the fixed 10 Hz packet counter: the period is loadable at runtime, and the timer runs continuously or one-shot. Requests are issued through a req/ack handshake with the packet FSM, and ticks that arrive while a request is still unacknowledged are counted as overruns. It sits between the system clock domain and the IR packet-builder FSM.

---
 rtl/packet_rate_timer.sv | 106 ++++++++++
 tb/tb_packet_rate_timer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/packet_rate_timer.sv
// Programmable packet-rate timer: loadable period, continuous or one-shot runs,
// and a req/ack handshake toward the packet FSM with saturating overrun counting.
module packet_rate_timer #(
  parameter int CNT_WIDTH      = 25,
  parameter int DEFAULT_PERIOD = 10000000,
  parameter int OVR_WIDTH      = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic                 MODE,
  input  logic                 START,
  input  logic [CNT_WIDTH-1:0] PERIOD_IN,
  input  logic                 PERIOD_LOAD,
  input  logic                 ACK,
  input  logic                 OVR_CLR,
  output logic [CNT_WIDTH-1:0] COUNT,
  output logic                 TICK,
  output logic                 SEND_REQ,
  output logic                 BUSY,
  output logic [OVR_WIDTH-1:0] OVERRUN_CNT
);

  localparam logic [CNT_WIDTH-1:0] DEF_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] active_period;
  logic [CNT_WIDTH-1:0] shadow_period;
  logic                 pending;
  logic                 terminal;
  logic                 transfer;
  logic                 overrun;

  // A clear that coincides with a lost tick leaves a count of one.
  function automatic logic [OVR_WIDTH-1:0] sat_ovr(input logic [OVR_WIDTH-1:0] cur,
                                                   input logic inc, input logic clr);
    if (clr) return inc ? OVR_WIDTH'(1) : '0;
    if (inc && (cur != '1)) return cur + OVR_WIDTH'(1);
    return cur;
  endfunction

  // Dropping ENABLE wins over a terminal count, so no tick is emitted then.
  always_comb begin
    terminal = (state == RUN) && ENABLE && (COUNT == active_period);
    transfer = pending && ((state == IDLE) || terminal);
    overrun  = terminal && SEND_REQ && !ACK;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      COUNT         <= '0;
      TICK          <= 1'b0;
      SEND_REQ      <= 1'b0;
      BUSY          <= 1'b0;
      OVERRUN_CNT   <= '0;
      active_period <= DEF_PERIOD;
      shadow_period <= DEF_PERIOD;
      pending       <= 1'b0;
    end else begin
      TICK <= terminal;

      case (state)
        IDLE: begin
          COUNT <= '0;
          if (ENABLE && (!MODE || START)) begin
            state <= RUN;
            BUSY  <= 1'b1;
          end
        end
        RUN: begin
          if (!ENABLE) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            COUNT <= '0;
          end else if (terminal) begin
            COUNT <= '0;
            if (MODE) begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end else begin
            COUNT <= COUNT + CNT_WIDTH'(1);
          end
        end
      endcase

      // A load on the transfer edge keeps pending set for the newer value.
      if (transfer) active_period <= shadow_period;
      if (PERIOD_LOAD) begin
        shadow_period <= PERIOD_IN;
        pending       <= 1'b1;
      end else if (transfer) begin
        pending <= 1'b0;
      end

      if (terminal)             SEND_REQ <= 1'b1;
      else if (SEND_REQ && ACK) SEND_REQ <= 1'b0;

      OVERRUN_CNT <= sat_ovr(OVERRUN_CNT, overrun, OVR_CLR);
    end
  end

endmodule

// File: tb/tb_packet_rate_timer.sv
// Scoreboard bench for packet_rate_timer: stimulus queues expected ticks,
// a negedge monitor checks each TICK against the head of the queue.
module tb_packet_rate_timer;

  localparam int CW = 25;
  localparam int OW = 8;

  logic          CLK = 1'b0;
  logic          RESET, ENABLE, MODE, START, PERIOD_LOAD, OVR_CLR;
  logic [CW-1:0] PERIOD_IN;
  logic          ACK;
  logic          auto_ack, ack_drv;
  logic [CW-1:0] COUNT;
  logic          TICK, SEND_REQ, BUSY;
  logic [OW-1:0] OVERRUN_CNT;

  typedef struct {
    int edge_no;
    int ovr;
  } tick_exp_t;

  tick_exp_t exp_q[$];
  int        cyc = 0;
  int        n_tests = 0;
  int        n_fail = 0;

  assign ACK = auto_ack ? SEND_REQ : ack_drv;

  packet_rate_timer #(.CNT_WIDTH(CW), .DEFAULT_PERIOD(20), .OVR_WIDTH(OW)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .MODE(MODE), .START(START),
    .PERIOD_IN(PERIOD_IN), .PERIOD_LOAD(PERIOD_LOAD), .ACK(ACK), .OVR_CLR(OVR_CLR),
    .COUNT(COUNT), .TICK(TICK), .SEND_REQ(SEND_REQ), .BUSY(BUSY),
    .OVERRUN_CNT(OVERRUN_CNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push_tick(input int edge_no, input int ovr);
    tick_exp_t t;
    t.edge_no = edge_no;
    t.ovr     = ovr;
    exp_q.push_back(t);
  endtask

  task automatic load_period(input int p);
    PERIOD_IN   = CW'(p);
    PERIOD_LOAD = 1'b1;
    goto(cyc + 1);
    PERIOD_LOAD = 1'b0;
    goto(cyc + 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, COUNT, 0);
    check({tag, "_tick"}, TICK, 0);
    check({tag, "_send_req"}, SEND_REQ, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_ovr"}, OVERRUN_CNT, 0);
  endtask

  always @(negedge CLK) begin
    if (TICK) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_tick: TICK=1 at edge %0d, no tick expected", cyc);
      end else begin
        tick_exp_t t;
        t = exp_q.pop_front();
        check("tick_edge", cyc, t.edge_no);
        check("tick_ovr", OVERRUN_CNT, t.ovr);
        check("tick_send_req", SEND_REQ, 1);
        check("tick_count", COUNT, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, s, m;
    RESET = 1'b1; ENABLE = 1'b0; MODE = 1'b0; START = 1'b0; PERIOD_LOAD = 1'b0;
    OVR_CLR = 1'b0; PERIOD_IN = '0; auto_ack = 1'b1; ack_drv = 1'b0;
    goto(2);
    RESET = 1'b0;
    check_reset_state("reset");

    // default period of 20 gives a 21-cycle tick interval
    ENABLE = 1'b1; e0 = cyc + 1;
    push_tick(e0 + 21, 0); push_tick(e0 + 42, 0);
    goto(e0);
    check("start_busy", BUSY, 1);
    check("start_count", COUNT, 0);
    goto(e0 + 45);
    ENABLE = 1'b0;
    goto(cyc + 2);

    // continuous run, P=3, every request acknowledged
    load_period(3);
    ENABLE = 1'b1; e0 = cyc + 1;
    push_tick(e0 + 4, 0); push_tick(e0 + 8, 0); push_tick(e0 + 12, 0);
    for (int i = 0; i < 5; i++) begin
      goto(e0 + i);
      check("cont_count_seq", COUNT, (i == 4) ? 0 : i);
    end
    goto(e0 + 13);
    check("cont_ovr", OVERRUN_CNT, 0);
    ENABLE = 1'b0;
    goto(cyc + 2);

    // P=9, ENABLE dropped at COUNT=7: cleared with no tick
    load_period(9);
    ENABLE = 1'b1; e0 = cyc + 1;
    goto(e0 + 7);
    check("drop_count7", COUNT, 7);
    ENABLE = 1'b0;
    goto(e0 + 8);
    check("drop_count0", COUNT, 0);
    check("drop_busy", BUSY, 0);
    check("drop_tick", TICK, 0);
    goto(cyc + 5);

    // reload 4 at COUNT=3 of a P=9 interval
    ENABLE = 1'b1; e0 = cyc + 1;
    push_tick(e0 + 10, 0); push_tick(e0 + 15, 0); push_tick(e0 + 20, 0);
    goto(e0 + 3);
    check("reload_count3", COUNT, 3);
    PERIOD_IN = CW'(4); PERIOD_LOAD = 1'b1;
    goto(e0 + 4);
    PERIOD_LOAD = 1'b0;
    goto(e0 + 21);
    ENABLE = 1'b0;
    goto(cyc + 2);

    // P=0: tick on every cycle in RUN
    load_period(0);
    ENABLE = 1'b1; e0 = cyc + 1;
    for (int i = 1; i <= 4; i++) push_tick(e0 + i, 0);
    goto(e0 + 4);
    ENABLE = 1'b0;
    goto(e0 + 6);

    // one-shot, P=5
    load_period(5);
    MODE = 1'b1; ENABLE = 1'b1;
    goto(cyc + 3);
    check("oneshot_wait_busy", BUSY, 0);
    START = 1'b1; s = cyc + 1;
    push_tick(s + 6, 0);
    goto(s);
    START = 1'b0;
    goto(s + 5);
    check("oneshot_busy_run", BUSY, 1);
    check("oneshot_count5", COUNT, 5);
    goto(s + 6);
    check("oneshot_busy_done", BUSY, 0);
    goto(s + 10);
    START = 1'b1; s = cyc + 1;
    push_tick(s + 6, 0);
    goto(s);
    START = 1'b0;
    goto(s + 8);
    ENABLE = 1'b0; MODE = 1'b0;
    goto(cyc + 2);

    // overrun, P=2, ACK held low except on tick 5; clear coincides with tick 263
    auto_ack = 1'b0; ack_drv = 1'b0;
    load_period(2);
    ENABLE = 1'b1; e0 = cyc + 1;
    m = 0;
    for (int k = 1; k <= 265; k++) begin
      if (k == 1)        m = 0;
      else if (k == 5)   m = m;
      else if (k == 263) m = 1;
      else if (m < 255)  m = m + 1;
      push_tick(e0 + 3 * k, m);
      goto(e0 + 3 * k - 1);
      ack_drv = (k == 5);
      OVR_CLR = (k == 263);
      goto(e0 + 3 * k);
      ack_drv = 1'b0;
      OVR_CLR = 1'b0;
      if (k == 262) check("ovr_saturated", OVERRUN_CNT, 255);
    end
    goto(e0 + 796);
    check("pre_reset_send_req", SEND_REQ, 1);
    check("pre_reset_ovr", OVERRUN_CNT, 3);
    check("pre_reset_busy", BUSY, 1);

    // reset with a request outstanding restores the default period too
    RESET = 1'b1;
    goto(cyc + 1);
    check_reset_state("midrun_reset");
    RESET = 1'b0; e0 = cyc + 1;
    push_tick(e0 + 21, 0);
    goto(e0 + 23);
    ENABLE = 1'b0;
    goto(cyc + 2);

    check("ticks_outstanding", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
